// File: rtl/otn_deframer.sv
// Serial OTN receive deframer: hunts for the frame alignment word, flywheels through
// lost FAS words, streams payload bytes and checks the per-frame CRC-8.
module otn_deframer #(
  parameter int          FRAME_BYTES = 64,
  parameter logic [15:0] FAS_WORD    = 16'hF628,
  parameter int          LOF_COUNT   = 3
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_line_bit,
  input  logic       i_line_bit_valid,
  output logic [7:0] o_frame_data,
  output logic       o_frame_data_valid,
  output logic       o_frame_data_sof,
  output logic       o_otn_tx_ack,
  output logic       o_crc_err,
  output logic       o_in_sync
);

  localparam int BYTE_W = $clog2(FRAME_BYTES);
  localparam int MISS_W = $clog2(LOF_COUNT + 1);

  localparam logic [1:0] ST_HUNT    = 2'd0;
  localparam logic [1:0] ST_PRESYNC = 2'd1;
  localparam logic [1:0] ST_SYNC    = 2'd2;

  localparam logic [BYTE_W-1:0] FAS_LAST_BYTE = BYTE_W'(1);
  localparam logic [BYTE_W-1:0] FIRST_PL_BYTE = BYTE_W'(2);
  localparam logic [BYTE_W-1:0] CRC_BYTE      = BYTE_W'(FRAME_BYTES - 1);
  localparam logic [MISS_W-1:0] LOF_LAST_MISS = MISS_W'(LOF_COUNT - 1);

  logic [1:0]        state, state_d;
  logic [15:0]       sh;
  logic [15:0]       sh_next;
  logic [2:0]        bit_cnt, bit_cnt_d;
  logic [BYTE_W-1:0] byte_cnt, byte_cnt_d;
  logic [MISS_W-1:0] miss, miss_d;
  logic [7:0]        crc, crc_d;

  // First pipeline stage: events decided on the edge that samples a byte's last bit.
  logic       pend_valid, pend_valid_d;
  logic       pend_sof, pend_sof_d;
  logic       pend_ack, pend_ack_d;
  logic       pend_err, pend_err_d;
  logic [7:0] pend_data, pend_data_d;

  logic       byte_done;
  logic       fas_hit;
  logic [7:0] byte_val;

  function automatic logic [7:0] crc8_update(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    end
    return r;
  endfunction

  assign sh_next   = {sh[14:0], i_line_bit};
  assign byte_done = i_line_bit_valid && (bit_cnt == 3'd7);
  assign fas_hit   = (sh_next == FAS_WORD);
  assign byte_val  = sh_next[7:0];
  assign o_in_sync = (state == ST_SYNC);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d      = state;
    bit_cnt_d    = bit_cnt;
    byte_cnt_d   = byte_cnt;
    miss_d       = miss;
    crc_d        = crc;
    pend_valid_d = 1'b0;
    pend_sof_d   = 1'b0;
    pend_ack_d   = 1'b0;
    pend_err_d   = 1'b0;
    pend_data_d  = pend_data;

    if (i_line_bit_valid) begin
      bit_cnt_d = bit_cnt + 3'd1;
      if (bit_cnt == 3'd7) begin
        byte_cnt_d = (byte_cnt == CRC_BYTE) ? '0 : byte_cnt + 1'b1;
      end

      case (state)
        ST_HUNT: begin
          // A hit means the FAS just ended, so the next bit opens byte 2.
          if (fas_hit) begin
            state_d    = ST_PRESYNC;
            bit_cnt_d  = '0;
            byte_cnt_d = FIRST_PL_BYTE;
          end
        end

        ST_PRESYNC: begin
          if (byte_done && byte_cnt == FAS_LAST_BYTE) begin
            if (fas_hit) begin
              state_d = ST_SYNC;
              miss_d  = '0;
              crc_d   = '0;
            end else begin
              state_d = ST_HUNT;
            end
          end
        end

        ST_SYNC: begin
          if (byte_done) begin
            if (byte_cnt == FAS_LAST_BYTE) begin
              if (fas_hit) begin
                miss_d = '0;
              end else if (miss == LOF_LAST_MISS) begin
                state_d = ST_HUNT;
                miss_d  = '0;
                crc_d   = '0;
              end else begin
                miss_d = miss + 1'b1;
              end
            end else if (byte_cnt == CRC_BYTE) begin
              pend_ack_d = (byte_val == crc);
              pend_err_d = (byte_val != crc);
              crc_d      = '0;
            end else if (byte_cnt != '0) begin
              pend_valid_d = 1'b1;
              pend_sof_d   = (byte_cnt == FIRST_PL_BYTE);
              pend_data_d  = byte_val;
              crc_d        = crc8_update(crc, byte_val);
            end
          end
        end

        default: state_d = ST_HUNT;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state              <= ST_HUNT;
      sh                 <= '0;
      bit_cnt            <= '0;
      byte_cnt           <= '0;
      miss               <= '0;
      crc                <= '0;
      pend_valid         <= 1'b0;
      pend_sof           <= 1'b0;
      pend_ack           <= 1'b0;
      pend_err           <= 1'b0;
      pend_data          <= '0;
      o_frame_data       <= '0;
      o_frame_data_valid <= 1'b0;
      o_frame_data_sof   <= 1'b0;
      o_otn_tx_ack       <= 1'b0;
      o_crc_err          <= 1'b0;
    end else begin
      if (i_line_bit_valid) begin
        sh <= sh_next;
      end
      state              <= state_d;
      bit_cnt            <= bit_cnt_d;
      byte_cnt           <= byte_cnt_d;
      miss               <= miss_d;
      crc                <= crc_d;
      pend_valid         <= pend_valid_d;
      pend_sof           <= pend_sof_d;
      pend_ack           <= pend_ack_d;
      pend_err           <= pend_err_d;
      pend_data          <= pend_data_d;
      o_frame_data       <= pend_data;
      o_frame_data_valid <= pend_valid;
      o_frame_data_sof   <= pend_sof;
      o_otn_tx_ack       <= pend_ack;
      o_crc_err          <= pend_err;
    end
  end

endmodule

// File: tb/tb_otn_deframer.sv
// Self-checking bench for otn_deframer: bit-level behavioural model plus scenario-level
// literal expectations on counts of strobes, acks and CRC errors.
module tb_otn_deframer;

  localparam int          FB  = 64;
  localparam logic [15:0] FAS = 16'hF628;
  localparam int          LOF = 3;

  typedef logic [7:0] bq_t [$];
  typedef enum {M_HUNT, M_PRE, M_SYNC} mode_t;

  logic       clk;
  logic       rst_n;
  logic       line_bit;
  logic       line_valid;
  logic [7:0] frame_data;
  logic       frame_data_valid;
  logic       frame_data_sof;
  logic       tx_ack;
  logic       crc_err;
  logic       in_sync;

  int checks = 0;
  int errors = 0;

  otn_deframer #(
    .FRAME_BYTES(FB),
    .FAS_WORD   (FAS),
    .LOF_COUNT  (LOF)
  ) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_line_bit        (line_bit),
    .i_line_bit_valid  (line_valid),
    .o_frame_data      (frame_data),
    .o_frame_data_valid(frame_data_valid),
    .o_frame_data_sof  (frame_data_sof),
    .o_otn_tx_ack      (tx_ack),
    .o_crc_err         (crc_err),
    .o_in_sync         (in_sync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // CRC as the remainder of M(x)*x^8 divided by x^8+x^2+x+1.
  function automatic logic [7:0] crc8_ref(input bq_t msg);
    logic [8:0] rem;
    int         nbits;
    rem   = '0;
    nbits = msg.size() * 8;
    for (int i = 0; i < nbits + 8; i++) begin
      rem = {rem[7:0], (i < nbits) ? msg[i / 8][7 - i % 8] : 1'b0};
      if (rem[8]) rem = rem ^ 9'h107;
    end
    return rem[7:0];
  endfunction

  // ---------------- behavioural model ----------------
  mode_t       m_mode;
  logic [15:0] m_hist;
  int          m_pos;
  int          m_miss;
  bq_t         m_pl;
  logic        p_valid, p_sof, p_ack, p_err;
  logic [7:0]  p_data;
  logic        e_valid, e_sof, e_ack, e_err;
  logic [7:0]  e_data;

  task automatic model_bit(input logic b);
    int         idx;
    logic [7:0] byt;
    logic [7:0] c;
    m_hist = {m_hist[14:0], b};
    if (m_mode == M_HUNT) begin
      if (m_hist == FAS) begin
        m_mode = M_PRE;
        m_pos  = 16;
      end
      return;
    end
    idx = m_pos / 8;
    byt = m_hist[7:0];
    if (m_pos % 8 == 7) begin
      if (idx == 1) begin
        m_pl.delete();
        if (m_mode == M_PRE) begin
          m_mode = (m_hist == FAS) ? M_SYNC : M_HUNT;
          m_miss = 0;
        end else if (m_hist == FAS) begin
          m_miss = 0;
        end else begin
          m_miss++;
          if (m_miss >= LOF) begin
            m_mode = M_HUNT;
            m_miss = 0;
          end
        end
      end else if (m_mode == M_SYNC && idx >= 2 && idx <= FB - 2) begin
        m_pl.push_back(byt);
        p_valid = 1'b1;
        p_data  = byt;
        p_sof   = (idx == 2);
      end else if (m_mode == M_SYNC && idx == FB - 1) begin
        c     = crc8_ref(m_pl);
        p_ack = (c == byt);
        p_err = (c != byt);
        m_pl.delete();
      end
    end
    m_pos = (m_pos + 1) % (FB * 8);
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_mode = M_HUNT; m_hist = '0; m_pos = 0; m_miss = 0; m_pl.delete();
      p_valid = 0; p_sof = 0; p_ack = 0; p_err = 0; p_data = '0;
      e_valid = 0; e_sof = 0; e_ack = 0; e_err = 0; e_data = '0;
    end else begin
      e_valid = p_valid; e_sof = p_sof; e_ack = p_ack; e_err = p_err; e_data = p_data;
      p_valid = 0; p_sof = 0; p_ack = 0; p_err = 0;
      if (line_valid) model_bit(line_bit);
    end
  end

  // ---------------- compare + monitor ----------------
  bit  cmp_en = 1'b0;
  int  mon_valid, mon_sof, mon_ack, mon_err, mon_unsync;
  bq_t mon_bytes;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("valid", 32'(frame_data_valid), 32'(e_valid));
      check("sof", 32'(frame_data_sof), 32'(e_sof));
      check("ack", 32'(tx_ack), 32'(e_ack));
      check("crc_err", 32'(crc_err), 32'(e_err));
      check("in_sync", 32'(in_sync), 32'(m_mode == M_SYNC));
      if (e_valid) check("data", 32'(frame_data), 32'(e_data));
      if (frame_data_valid) begin
        mon_valid++;
        mon_bytes.push_back(frame_data);
      end
      if (frame_data_sof) mon_sof++;
      if (tx_ack) mon_ack++;
      if (crc_err) mon_err++;
      if (!in_sync) mon_unsync++;
    end
  end

  task automatic clear_mon();
    mon_valid = 0; mon_sof = 0; mon_ack = 0; mon_err = 0; mon_unsync = 0;
    mon_bytes.delete();
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] frame_buf [FB];

  task automatic fix_crc();
    bq_t pl;
    for (int i = 2; i < FB - 1; i++) pl.push_back(frame_buf[i]);
    frame_buf[FB-1] = crc8_ref(pl);
  endtask

  task automatic build_frame(input logic [15:0] fas, input bit random_pl);
    frame_buf[0] = fas[15:8];
    frame_buf[1] = fas[7:0];
    for (int i = 2; i < FB - 1; i++) begin
      frame_buf[i] = random_pl ? 8'($urandom_range(0, 255)) : 8'(i - 2);
    end
    fix_crc();
  endtask

  task automatic send_bit(input logic b, input bit gaps);
    if (gaps) begin
      while ($urandom_range(0, 1) == 0) begin
        @(posedge clk);
        #1;
        line_bit = 1'($urandom_range(0, 1));
      end
    end
    line_bit   = b;
    line_valid = 1'b1;
    @(posedge clk);
    #1;
    line_valid = 1'b0;
    line_bit   = 1'($urandom_range(0, 1));
  endtask

  task automatic send_frame(input int first_bit, input int end_bit, input bit gaps);
    for (int p = first_bit; p < end_bit; p++) send_bit(frame_buf[p / 8][7 - p % 8], gaps);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bq_t pin;
    rst_n      = 1'b0;
    line_valid = 1'b0;
    line_bit   = 1'b0;

    // Pin the reference CRC with hand-known values.
    pin = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    check("crc_ref_check_string", 32'(crc8_ref(pin)), 32'h0000_00F4);
    pin = '{8'h01};
    check("crc_ref_one", 32'(crc8_ref(pin)), 32'h0000_0007);

    idle(3);
    cmp_en = 1'b1;
    check("rst_valid", 32'(frame_data_valid), 32'd0);
    check("rst_ack", 32'(tx_ack), 32'd0);
    check("rst_err", 32'(crc_err), 32'd0);
    check("rst_sync", 32'(in_sync), 32'd0);
    check("rst_data", 32'(frame_data), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // 1: three good ramp frames, first one only locks.
    clear_mon();
    build_frame(FAS, 1'b0);
    repeat (3) send_frame(0, FB * 8, 1'b0);
    idle(4);
    check("s1_valid_cnt", 32'(mon_valid), 32'd122);
    check("s1_sof_cnt", 32'(mon_sof), 32'd2);
    check("s1_ack_cnt", 32'(mon_ack), 32'd2);
    check("s1_err_cnt", 32'(mon_err), 32'd0);
    check("s1_in_sync", 32'(in_sync), 32'd1);
    if (mon_bytes.size() == 122) begin
      check("s1_first_byte", 32'(mon_bytes[0]), 32'h00);
      check("s1_last_byte", 32'(mon_bytes[60]), 32'h3C);
      check("s1_f2_first_byte", 32'(mon_bytes[61]), 32'h00);
    end

    // 2: one corrupted payload bit.
    clear_mon();
    build_frame(FAS, 1'b0);
    frame_buf[20] = frame_buf[20] ^ 8'h10;
    send_frame(0, FB * 8, 1'b0);
    idle(4);
    check("s2_err_cnt", 32'(mon_err), 32'd1);
    check("s2_ack_cnt", 32'(mon_ack), 32'd0);
    check("s2_valid_cnt", 32'(mon_valid), 32'd61);
    check("s2_unsync_cycles", 32'(mon_unsync), 32'd0);

    // 3a: two bad FAS frames then a good one, flywheel keeps sync.
    clear_mon();
    repeat (2) begin
      build_frame(16'h0000, 1'b1);
      send_frame(0, FB * 8, 1'b0);
    end
    build_frame(FAS, 1'b1);
    send_frame(0, FB * 8, 1'b0);
    idle(4);
    check("s3a_valid_cnt", 32'(mon_valid), 32'd183);
    check("s3a_ack_cnt", 32'(mon_ack), 32'd3);
    check("s3a_unsync_cycles", 32'(mon_unsync), 32'd0);

    // 3b: three bad FAS frames in a row lose sync at the third FAS end.
    clear_mon();
    build_frame(16'h0000, 1'b0);
    repeat (2) send_frame(0, FB * 8, 1'b0);
    check("s3b_sync_before_3rd", 32'(in_sync), 32'd1);
    send_frame(0, 16, 1'b0);
    check("s3b_sync_after_3rd_fas", 32'(in_sync), 32'd0);
    send_frame(16, FB * 8, 1'b0);
    idle(4);
    check("s3b_valid_cnt", 32'(mon_valid), 32'd122);
    check("s3b_ack_cnt", 32'(mon_ack), 32'd2);

    // 4: start mid-frame with a FAS-like word in the payload.
    pulse_reset();
    clear_mon();
    build_frame(FAS, 1'b0);
    frame_buf[10] = 8'hF6;
    frame_buf[11] = 8'h28;
    fix_crc();
    send_frame(5, FB * 8, 1'b0);
    build_frame(FAS, 1'b0);
    repeat (4) send_frame(0, FB * 8, 1'b0);
    idle(4);
    check("s4_valid_cnt", 32'(mon_valid), 32'd122);
    check("s4_ack_cnt", 32'(mon_ack), 32'd2);
    check("s4_err_cnt", 32'(mon_err), 32'd0);
    check("s4_in_sync", 32'(in_sync), 32'd1);

    // 5: random payload with 50% valid gaps.
    clear_mon();
    build_frame(FAS, 1'b1);
    send_frame(0, FB * 8, 1'b1);
    idle(4);
    check("s5_valid_cnt", 32'(mon_valid), 32'd61);
    check("s5_ack_cnt", 32'(mon_ack), 32'd1);
    check("s5_err_cnt", 32'(mon_err), 32'd0);
    for (int i = 0; i < 61; i++) begin
      if (i < mon_bytes.size()) check("s5_byte", 32'(mon_bytes[i]), 32'(frame_buf[i + 2]));
    end

    // 6: reset mid-payload, then relock through PRESYNC.
    build_frame(FAS, 1'b0);
    send_frame(0, 30 * 8, 1'b0);
    pulse_reset();
    check("s6_rst_valid", 32'(frame_data_valid), 32'd0);
    check("s6_rst_sof", 32'(frame_data_sof), 32'd0);
    check("s6_rst_ack", 32'(tx_ack), 32'd0);
    check("s6_rst_err", 32'(crc_err), 32'd0);
    check("s6_rst_sync", 32'(in_sync), 32'd0);
    check("s6_rst_data", 32'(frame_data), 32'd0);
    clear_mon();
    repeat (2) send_frame(0, FB * 8, 1'b0);
    idle(4);
    check("s6_valid_cnt", 32'(mon_valid), 32'd61);
    check("s6_ack_cnt", 32'(mon_ack), 32'd1);
    check("s6_sof_cnt", 32'(mon_sof), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
